// File: rtl/seq_pkg.sv
// Shared types and constants for the SEQ Y86-64 multi-cycle sequencer.
package seq_pkg;

    localparam logic [3:0] IC_HALT  = 4'h0;
    localparam logic [3:0] IC_NOP   = 4'h1;
    localparam logic [3:0] IC_CMOV  = 4'h2;
    localparam logic [3:0] IC_IRMOV = 4'h3;
    localparam logic [3:0] IC_RMMOV = 4'h4;
    localparam logic [3:0] IC_MRMOV = 4'h5;
    localparam logic [3:0] IC_OPQ   = 4'h6;
    localparam logic [3:0] IC_JXX   = 4'h7;
    localparam logic [3:0] IC_CALL  = 4'h8;
    localparam logic [3:0] IC_RET   = 4'h9;
    localparam logic [3:0] IC_PUSH  = 4'hA;
    localparam logic [3:0] IC_POP   = 4'hB;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    // Instructions that touch data memory in the MEMORY stage.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        case (ic)
            IC_RMMOV, IC_MRMOV, IC_CALL, IC_RET, IC_PUSH, IC_POP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_stage_ctrl_cc.sv
// Condition-code register: loads ALU flags on demand, resets to Z=1 S=0 O=0.
module seq_cc_reg
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  cc_t  cc_in,
    output cc_t  cc_out
);

    cc_t cc_d;
    cc_t cc_q;

    always_comb begin
        cc_d = cc_q;
        if (load) begin
            cc_d = cc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= CC_RESET;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc_out = cc_q;

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle SEQ sequencer: one-hot stage enables, condition codes,
// data-memory handshake with timeout and processor status.
module seq_stage_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             mem_req,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    stat_e              stat_q, stat_d;
    logic [3:0]         icode_q, icode_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               cc_load;
    logic               mem_access;
    cc_t                alu_cc;
    cc_t                cc_cur;

    assign mem_access = (state_q == S_MEMORY) && is_mem_icode(icode_q);
    assign alu_cc     = '{zf: alu_zf, sf: alu_sf, of: alu_of};

    seq_cc_reg u_cc (
        .clk    (clk),
        .rst    (rst),
        .load   (cc_load),
        .cc_in  (alu_cc),
        .cc_out (cc_cur)
    );

    // Next-state, fault capture and counters.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        icode_d = icode_q;
        count_d = count_q;
        wait_d  = wait_q;
        cc_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else if (icode == IC_HALT) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    icode_d = icode;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                cc_load = (icode_q == IC_OPQ);
                wait_d  = '0;
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                if (!mem_access) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ready) begin
                    wait_d = '0;
                    if (dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else begin
                    // Count unanswered request cycles; give up at the limit.
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end
                end
            end
            S_WRITEBACK: begin
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                count_d = count_q + CNT_W'(1);
                state_d = step_mode ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= IC_HALT;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    // Moore outputs decoded straight from the state register.
    assign fetch_en    = (state_q == S_FETCH);
    assign decode_en   = (state_q == S_DECODE);
    assign exec_en     = (state_q == S_EXECUTE);
    assign mem_en      = (state_q == S_MEMORY);
    assign wb_en       = (state_q == S_WRITEBACK);
    assign pc_en       = (state_q == S_PCUPD);
    assign mem_req     = mem_access;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign stat        = stat_q;
    assign instr_count = count_q;
    assign cc_zf       = cc_cur.zf;
    assign cc_sf       = cc_cur.sf;
    assign cc_of       = cc_cur.of;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: per-cycle expectations queued before each edge.
module tb_seq_stage_ctrl;

    localparam logic [5:0] EN_0 = 6'b000000;
    localparam logic [5:0] EN_F = 6'b100000;
    localparam logic [5:0] EN_D = 6'b010000;
    localparam logic [5:0] EN_E = 6'b001000;
    localparam logic [5:0] EN_M = 6'b000100;
    localparam logic [5:0] EN_W = 6'b000010;
    localparam logic [5:0] EN_P = 6'b000001;
    localparam logic [1:0] BH_IDLE = 2'b00;
    localparam logic [1:0] BH_BUSY = 2'b10;
    localparam logic [1:0] BH_HALT = 2'b01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic        instr_valid = 1'b1;
    logic        imem_error = 1'b0;
    logic        mem_ready = 1'b0;
    logic        dmem_error = 1'b0;
    logic        alu_zf = 1'b0;
    logic        alu_sf = 1'b0;
    logic        alu_of = 1'b0;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
    logic        mem_req, cc_zf, cc_sf, cc_of, busy, halted;
    logic [2:0]  stat;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]  en;
        logic        mreq;
        logic [2:0]  st;
        logic [2:0]  cc;
        logic [1:0]  bh;
        logic [31:0] cnt;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];

    seq_stage_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .step_mode   (step_mode),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .mem_ready   (mem_ready),
        .dmem_error  (dmem_error),
        .alu_zf      (alu_zf),
        .alu_sf      (alu_sf),
        .alu_of      (alu_of),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .pc_en       (pc_en),
        .mem_req     (mem_req),
        .cc_zf       (cc_zf),
        .cc_sf       (cc_sf),
        .cc_of       (cc_of),
        .stat        (stat),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Queue the outputs expected after the coming edge, clock, then pop and compare.
    task automatic tick(input string tag, input logic [5:0] en, input logic mreq,
                        input logic [2:0] st, input logic [2:0] cc,
                        input logic [1:0] bh, input logic [31:0] cnt);
        obs_t  e;
        obs_t  o;
        string t;
        exp_q.push_back('{en: en, mreq: mreq, st: st, cc: cc, bh: bh, cnt: cnt});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = '{en: {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en}, mreq: mem_req,
              st: stat, cc: {cc_zf, cc_sf, cc_of}, bh: {busy, halted}, cnt: instr_count};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed en=%b mreq=%b stat=%0d cc=%b bh=%b cnt=%0d expected en=%b mreq=%b stat=%0d cc=%b bh=%b cnt=%0d",
                   t, o.en, o.mreq, o.st, o.cc, o.bh, o.cnt, e.en, e.mreq, e.st, e.cc, e.bh, e.cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick("reset", EN_0, 1'b0, 3'd1, 3'b100, BH_IDLE, 0);
        rst = 1'b0;
        tick("idle_hold", EN_0, 1'b0, 3'd1, 3'b100, BH_IDLE, 0);

        // nop: six one-hot stages, then FETCH again
        start = 1'b1; icode = 4'h1;
        tick("nop_f", EN_F, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        start = 1'b0;
        tick("nop_d", EN_D, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        tick("nop_e", EN_E, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        mem_ready = 1'b1;
        tick("nop_m", EN_M, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        tick("nop_w", EN_W, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        mem_ready = 1'b0;
        tick("nop_p", EN_P, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        start = 1'b1;
        tick("nop_refetch", EN_F, 1'b0, 3'd1, 3'b100, BH_BUSY, 1);
        start = 1'b0;

        // OPq loads CC from ALU flags after EXECUTE
        icode = 4'h6;
        tick("opq_d", EN_D, 1'b0, 3'd1, 3'b100, BH_BUSY, 1);
        tick("opq_e", EN_E, 1'b0, 3'd1, 3'b100, BH_BUSY, 1);
        alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b0;
        tick("opq_cc_new", EN_M, 1'b0, 3'd1, 3'b010, BH_BUSY, 1);
        tick("opq_w", EN_W, 1'b0, 3'd1, 3'b010, BH_BUSY, 1);
        tick("opq_p", EN_P, 1'b0, 3'd1, 3'b010, BH_BUSY, 1);
        tick("opq_f", EN_F, 1'b0, 3'd1, 3'b010, BH_BUSY, 2);

        // nop with different flags must not touch CC
        icode = 4'h1; alu_zf = 1'b1; alu_sf = 1'b0; alu_of = 1'b1;
        tick("nop2_d", EN_D, 1'b0, 3'd1, 3'b010, BH_BUSY, 2);
        tick("nop2_e", EN_E, 1'b0, 3'd1, 3'b010, BH_BUSY, 2);
        tick("nop2_cc_hold", EN_M, 1'b0, 3'd1, 3'b010, BH_BUSY, 2);
        tick("nop2_w", EN_W, 1'b0, 3'd1, 3'b010, BH_BUSY, 2);
        tick("nop2_p", EN_P, 1'b0, 3'd1, 3'b010, BH_BUSY, 2);
        tick("nop2_f", EN_F, 1'b0, 3'd1, 3'b010, BH_BUSY, 3);

        // mrmovq with mem_ready on the 4th MEMORY cycle: 9-cycle instruction
        icode = 4'h5;
        tick("mr_d", EN_D, 1'b0, 3'd1, 3'b010, BH_BUSY, 3);
        tick("mr_e", EN_E, 1'b0, 3'd1, 3'b010, BH_BUSY, 3);
        tick("mr_m1", EN_M, 1'b1, 3'd1, 3'b010, BH_BUSY, 3);
        tick("mr_m2", EN_M, 1'b1, 3'd1, 3'b010, BH_BUSY, 3);
        tick("mr_m3", EN_M, 1'b1, 3'd1, 3'b010, BH_BUSY, 3);
        tick("mr_m4", EN_M, 1'b1, 3'd1, 3'b010, BH_BUSY, 3);
        mem_ready = 1'b1;
        tick("mr_w", EN_W, 1'b0, 3'd1, 3'b010, BH_BUSY, 3);
        mem_ready = 1'b0;
        tick("mr_p", EN_P, 1'b0, 3'd1, 3'b010, BH_BUSY, 3);
        tick("mr_f", EN_F, 1'b0, 3'd1, 3'b010, BH_BUSY, 4);

        // step_mode returns to IDLE, start resumes
        icode = 4'h1; step_mode = 1'b1;
        tick("st_d", EN_D, 1'b0, 3'd1, 3'b010, BH_BUSY, 4);
        tick("st_e", EN_E, 1'b0, 3'd1, 3'b010, BH_BUSY, 4);
        tick("st_m", EN_M, 1'b0, 3'd1, 3'b010, BH_BUSY, 4);
        tick("st_w", EN_W, 1'b0, 3'd1, 3'b010, BH_BUSY, 4);
        tick("st_p", EN_P, 1'b0, 3'd1, 3'b010, BH_BUSY, 4);
        tick("st_idle", EN_0, 1'b0, 3'd1, 3'b010, BH_IDLE, 5);
        tick("st_idle_wait", EN_0, 1'b0, 3'd1, 3'b010, BH_IDLE, 5);
        start = 1'b1; step_mode = 1'b0;
        tick("st_resume", EN_F, 1'b0, 3'd1, 3'b010, BH_BUSY, 5);
        start = 1'b0;

        // reset during MEMORY (start also high: reset wins)
        icode = 4'h5;
        tick("rm_d", EN_D, 1'b0, 3'd1, 3'b010, BH_BUSY, 5);
        tick("rm_e", EN_E, 1'b0, 3'd1, 3'b010, BH_BUSY, 5);
        tick("rm_m", EN_M, 1'b1, 3'd1, 3'b010, BH_BUSY, 5);
        rst = 1'b1; start = 1'b1;
        tick("rm_reset", EN_0, 1'b0, 3'd1, 3'b100, BH_IDLE, 0);
        rst = 1'b0;

        // one nop then a memory instruction that never gets mem_ready
        icode = 4'h1;
        tick("to_nop_f", EN_F, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        start = 1'b0;
        tick("to_nop_d", EN_D, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        tick("to_nop_e", EN_E, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        tick("to_nop_m", EN_M, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        tick("to_nop_w", EN_W, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        tick("to_nop_p", EN_P, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        tick("to_f", EN_F, 1'b0, 3'd1, 3'b100, BH_BUSY, 1);
        icode = 4'h5;
        tick("to_d", EN_D, 1'b0, 3'd1, 3'b100, BH_BUSY, 1);
        tick("to_e", EN_E, 1'b0, 3'd1, 3'b100, BH_BUSY, 1);
        for (int i = 1; i <= 16; i++) begin
            tick($sformatf("to_m%0d", i), EN_M, 1'b1, 3'd1, 3'b100, BH_BUSY, 1);
        end
        tick("to_halt_adr", EN_0, 1'b0, 3'd3, 3'b100, BH_HALT, 1);
        start = 1'b1;
        tick("to_halt_start_ignored", EN_0, 1'b0, 3'd3, 3'b100, BH_HALT, 1);

        // halt instruction
        rst = 1'b1;
        tick("h_reset", EN_0, 1'b0, 3'd1, 3'b100, BH_IDLE, 0);
        rst = 1'b0; start = 1'b1; icode = 4'h0;
        tick("h_f", EN_F, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        start = 1'b0;
        tick("h_halt", EN_0, 1'b0, 3'd2, 3'b100, BH_HALT, 1);
        start = 1'b1;
        tick("h_start_ignored", EN_0, 1'b0, 3'd2, 3'b100, BH_HALT, 1);

        // illegal instruction
        rst = 1'b1;
        tick("ins_reset", EN_0, 1'b0, 3'd1, 3'b100, BH_IDLE, 0);
        rst = 1'b0; icode = 4'h1;
        tick("ins_f", EN_F, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        start = 1'b0; instr_valid = 1'b0;
        tick("ins_halt", EN_0, 1'b0, 3'd4, 3'b100, BH_HALT, 0);

        // imem_error outranks invalid
        rst = 1'b1;
        tick("ie_reset", EN_0, 1'b0, 3'd1, 3'b100, BH_IDLE, 0);
        rst = 1'b0; start = 1'b1;
        tick("ie_f", EN_F, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        start = 1'b0; imem_error = 1'b1;
        tick("ie_halt_adr", EN_0, 1'b0, 3'd3, 3'b100, BH_HALT, 0);
        imem_error = 1'b0; instr_valid = 1'b1;

        // data-memory fault on the first ready cycle
        rst = 1'b1;
        tick("de_reset", EN_0, 1'b0, 3'd1, 3'b100, BH_IDLE, 0);
        rst = 1'b0; start = 1'b1; icode = 4'h4;
        tick("de_f", EN_F, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        start = 1'b0;
        tick("de_d", EN_D, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        tick("de_e", EN_E, 1'b0, 3'd1, 3'b100, BH_BUSY, 0);
        tick("de_m", EN_M, 1'b1, 3'd1, 3'b100, BH_BUSY, 0);
        mem_ready = 1'b1; dmem_error = 1'b1;
        tick("de_halt_adr", EN_0, 1'b0, 3'd3, 3'b100, BH_HALT, 0);
        mem_ready = 1'b0; dmem_error = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
Multi-cycle sequencer for the SEQ Y86-64 core. It steps one instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD with one-hot stage enables. It owns the registered condition codes (ZF/SF/OF) consumed by the execute stage's cnd logic. It handles the data-memory handshake and timeout, and drives the processor status code.

Parameters:
MEM_TIMEOUT, 16, max MEMORY cycles with mem_req high and no mem_ready before an ADR fault (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
start  in  1  begin/resume execution; honoured only in IDLE
step_mode  in  1  1 = return to IDLE after each retired instruction
icode  in  4  instruction code from fetch; sampled at end of FETCH
instr_valid  in  1  fetch decoded a legal icode/ifun
imem_error  in  1  fetch address fault
mem_ready  in  1  data memory completes request this cycle
dmem_error  in  1  data memory fault; qualified by mem_req & mem_ready
alu_zf  in  1  execute-stage flag results for current instruction
alu_sf  in  1  execute-stage flag results for current instruction
alu_of  in  1  execute-stage flag results for current instruction
fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  out  1 each  stage enables, one-hot or all zero
mem_req  out  1  data memory request
cc_zf, cc_sf, cc_of  out  1 each  registered condition codes
stat  out  3  1=AOK 2=HLT 3=ADR 4=INS
busy  out  1  state not IDLE and not HALT
halted  out  1  state == HALT
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset, applied at any edge including mid-instruction:
  - next state IDLE; all enables and mem_req 0; stat=1.
  - cc_zf=1, cc_sf=0, cc_of=0; instr_count=0; timeout counter=0; latched icode=0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. Outputs are Moore, decoded from the state register: the enable for a state is high exactly in the cycles the FSM occupies it.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH, 1 cycle. At end of cycle, evaluated in priority order:
  - imem_error -> HALT, stat=3.
  - !instr_valid -> HALT, stat=4.
  - icode==0 (halt) -> HALT, stat=2, instr_count+1.
  - otherwise latch icode -> DECODE.
- DECODE -> EXECUTE, 1 cycle.
- EXECUTE, 1 cycle, then -> MEMORY.
  - CC loaded from alu_* at end of cycle only when latched icode==6 (OPq); otherwise CC holds.
  - The new CC is visible the cycle after EXECUTE, never during it.
- MEMORY:
  - Memory icodes (4,5,8,9,A,B): mem_req=1 from entry until a cycle with mem_ready=1 inclusive.
    - mem_ready & dmem_error -> HALT, stat=3.
    - mem_ready & !dmem_error -> WRITEBACK.
    - Wait counter increments on each mem_req & !mem_ready cycle. When it reaches MEM_TIMEOUT -> HALT, stat=3.
  - Other icodes: 1 cycle with mem_req=0; mem_ready ignored.
- WRITEBACK -> PCUPD, 1 cycle.
- PCUPD, 1 cycle: instr_count+1 (wraps modulo 2^CNT_W); step_mode ? IDLE : FETCH.
- HALT: terminal until rst. start ignored; all enables 0; stat holds the fault code.
- Faulted instructions assert neither wb_en nor pc_en and do not increment instr_count; halt (icode 0) is the exception.
- Latency:
  - non-memory instruction: 6 cycles from FETCH entry to next FETCH entry.
  - memory instruction: 6 + number of waited cycles.
- start while busy: ignored. start together with rst: rst wins.

Decomposition:
- Package seq_pkg:
  - icode constants (HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B).
  - stat codes AOK/HLT/ADR/INS.
  - stage state enum.
  - function is_mem_icode.
- Sub-module seq_cc_reg: 3-bit CC register with sync reset to Z=1/S=0/O=0 and load enable.

Test Plan:
- Reset, start=1 pulse, icode=1 (nop), instr_valid=1 -> enables fetch..pc one-hot in cycles 1-6, FETCH again cycle 7, instr_count=1, mem_req never high.
- OPq: icode=6, alu_zf=0/sf=1/of=0 during EXECUTE -> next cycle cc=0/1/0. Then nop with alu flags 1/0/1 -> cc unchanged.
- mrmovq (icode=5), mem_ready high on the 4th MEMORY cycle -> mem_req high exactly 4 cycles, wb_en on the following cycle, instruction takes 9 cycles.
- icode=5, mem_ready never asserted, MEM_TIMEOUT=16 -> HALT after 16 MEMORY cycles. stat=3, halted=1, wb_en/pc_en never high, instr_count unchanged.
- icode=0 -> HALT after FETCH, stat=2, instr_count+1, later start pulse ignored. Separately, instr_valid=0 -> stat=4; imem_error=1 with instr_valid=0 -> stat=3 (priority).
- step_mode=1 -> IDLE after PCUPD, busy=0, next start resumes FETCH. rst asserted during MEMORY -> IDLE next cycle, mem_req=0, cc=1/0/0, instr_count=0, stat=1.
